// File: rtl/phy_nibble_tx.sv
// -----------------------------------------------------------------------------
// phy_nibble_tx
//   Final transmit stage. Takes one frame descriptor (length in bytes) and the
//   matching byte stream. It then drives the 4-bit PHY interface with the
//   preamble nibbles, the SFD nibble and the frame data (low nibble first),
//   followed by a fixed inter-frame gap. If a byte is missing when it is
//   needed (underrun), the frame is aborted and the rest of its bytes are
//   drained and discarded.
//
// Ports
//   clk_phy       in   PHY clock (only clock of this block)
//   reset         in   synchronous, active-high reset
//   desc_valid    in   descriptor available
//   desc_len      in   frame length in bytes (LEN_W)
//   desc_ready    out  descriptor accepted on desc_valid && desc_ready
//   byte_data     in   frame byte
//   byte_valid    in   byte_data valid
//   byte_ready    out  byte consumed on byte_valid && byte_ready
//   phy_data_out  out  PHY nibble, registered
//   phy_tx_en     out  PHY transmit enable, registered
//   underrun      out  1-cycle pulse, frame aborted for lack of a byte
//   frame_done    out  1-cycle pulse, frame slot complete
// -----------------------------------------------------------------------------
module phy_nibble_tx #(
    parameter int         LEN_W       = 12,
    parameter int         PRE_NIBBLES = 15,
    parameter logic [3:0] SFD_NIBBLE  = 4'hD,
    parameter int         IFG_CYCLES  = 24
) (
    input  logic             clk_phy,
    input  logic             reset,
    input  logic             desc_valid,
    input  logic [LEN_W-1:0] desc_len,
    output logic             desc_ready,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [3:0]       phy_data_out,
    output logic             phy_tx_en,
    output logic             underrun,
    output logic             frame_done
);

    // One counter serves both the preamble and the inter-frame gap.
    localparam int CNT_MAX = (IFG_CYCLES > PRE_NIBBLES) ? IFG_CYCLES : PRE_NIBBLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DLO,
        DHI,
        DRAIN,
        IFG
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // Bytes of the current frame not yet taken from the byte stream.
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic [7:0]       byte_reg, byte_next;
    logic [3:0]       data_reg, data_next;
    logic             tx_en_reg, tx_en_next;
    logic             underrun_reg, underrun_next;
    logic             frame_done_reg, frame_done_next;
    logic             fetch;

    always_ff @(posedge clk_phy) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            rem_reg        <= '0;
            byte_reg       <= '0;
            data_reg       <= '0;
            tx_en_reg      <= 1'b0;
            underrun_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rem_reg        <= rem_next;
            byte_reg       <= byte_next;
            data_reg       <= data_next;
            tx_en_reg      <= tx_en_next;
            underrun_reg   <= underrun_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Lookahead fetch: the byte for the next DLO is requested during SFD,
    // or during DHI while bytes remain. Then the low nibble can be driven
    // straight from byte_data on the capture edge.
    assign fetch = (state_reg == SFD) || ((state_reg == DHI) && (rem_reg != '0));

    // The *_next output values describe what the PHY shows in the cycle
    // after this edge. The output pins are therefore pure registers.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        rem_next        = rem_reg;
        byte_next       = byte_reg;
        data_next       = 4'h0;
        tx_en_next      = 1'b0;
        underrun_next   = 1'b0;
        frame_done_next = 1'b0;
        desc_ready      = 1'b0;
        byte_ready      = 1'b0;

        case (state_reg)
            IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    if (desc_len == '0) begin
                        // Empty frame: the slot completes with no PHY activity and no gap.
                        frame_done_next = 1'b1;
                    end else begin
                        state_next = PRE;
                        rem_next   = desc_len;
                        cnt_next   = '0;
                        tx_en_next = 1'b1;
                        data_next  = 4'h5;
                    end
                end
            end

            PRE: begin
                tx_en_next = 1'b1;
                if (cnt_reg == CNT_W'(PRE_NIBBLES - 1)) begin
                    state_next = SFD;
                    data_next  = SFD_NIBBLE;
                end else begin
                    cnt_next  = cnt_reg + CNT_W'(1);
                    data_next = 4'h5;
                end
            end

            SFD, DHI: begin
                if (fetch) begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        state_next = DLO;
                        byte_next  = byte_data;
                        rem_next   = rem_reg - LEN_W'(1);
                        tx_en_next = 1'b1;
                        data_next  = byte_data[3:0];
                    end else begin
                        // Abort. rem_reg still counts every byte not yet taken,
                        // so it becomes the drain length unchanged.
                        state_next    = DRAIN;
                        underrun_next = 1'b1;
                    end
                end else begin
                    state_next = IFG;
                    cnt_next   = '0;
                end
            end

            DLO: begin
                state_next = DHI;
                tx_en_next = 1'b1;
                data_next  = byte_reg[7:4];
            end

            DRAIN: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    rem_next = rem_reg - LEN_W'(1);
                    if (rem_reg == LEN_W'(1)) begin
                        state_next = IFG;
                        cnt_next   = '0;
                    end
                end
            end

            IFG: begin
                if (cnt_reg == CNT_W'(IFG_CYCLES - 1)) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign phy_data_out = data_reg;
    assign phy_tx_en    = tx_en_reg;
    assign underrun     = underrun_reg;
    assign frame_done   = frame_done_reg;

endmodule
